// File: rtl/mem_access_unit.sv
// Memory-stage access unit: turns a MEM-stage operation into a data-memory
// request/grant/response transaction with lane alignment, extension and faults.
module mem_access_unit #(
  parameter int XLEN    = 32,
  parameter int AW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i,
  input  logic [4:0]        memOp_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [XLEN-1:0]   wdata_i,
  input  logic [4:0]        rd_i,
  output logic              stall_o,
  output logic              done_o,
  output logic [XLEN-1:0]   rdata_o,
  output logic [4:0]        rd_o,
  output logic              exc_o,
  output logic [1:0]        exc_cause_o,
  output logic              dm_req_o,
  output logic              dm_we_o,
  output logic [AW-1:0]     dm_addr_o,
  output logic [XLEN/8-1:0] dm_be_o,
  output logic [XLEN-1:0]   dm_wdata_o,
  input  logic              dm_gnt_i,
  input  logic              dm_rvalid_i,
  input  logic [XLEN-1:0]   dm_rdata_i
);

  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t            r_state, w_nx;
  logic [CW-1:0]     r_cnt;
  logic [2:0]        r_f3;
  logic              r_we;
  logic [OW-1:0]     r_off;
  logic [4:0]        r_rd_lat;
  logic              r_req, r_done, r_exc, r_dm_we;
  logic [1:0]        r_cause;
  logic [AW-1:0]     r_dm_addr;
  logic [NB-1:0]     r_dm_be;
  logic [XLEN-1:0]   r_dm_wdata, r_rdata;
  logic [4:0]        r_rd;

  logic [2:0]        w_f3;
  logic              w_we, w_en, w_accept, w_illegal, w_misal, w_tmo, w_load_done;
  logic [3:0]        w_size;
  logic [OW-1:0]     w_off, w_amask;
  logic [NB-1:0]     w_bmask;
  logic [1:0]        w_fault, w_cause_nx;
  logic [XLEN-1:0]   w_sh, w_keep, w_ext;
  logic              w_sbit;

  assign w_f3     = memOp_i[4:2];
  assign w_we     = memOp_i[1];
  assign w_en     = memOp_i[0];
  assign w_accept = (r_state == S_IDLE) && valid_i && w_en;
  assign w_size   = 4'd1 << w_f3[1:0];
  assign w_amask  = OW'(w_size - 4'd1);
  assign w_off    = addr_i[OW-1:0];
  assign w_bmask  = (NB'(1) << w_size) - NB'(1);
  assign w_misal  = |(w_off & w_amask);
  assign w_tmo    = (r_cnt >= CW'(TIMEOUT - 1));

  // Illegal-width classification and fault priority (illegal over misaligned)
  always_comb begin
    w_illegal = 1'b0;
    w_fault   = 2'b00;
    if (w_f3 == 3'b111) begin
      w_illegal = 1'b1;
    end else if (w_we && w_f3[2]) begin
      w_illegal = 1'b1;
    end else if ((XLEN == 32) && ((w_f3 == 3'b011) || (w_f3 == 3'b110))) begin
      w_illegal = 1'b1;
    end else begin
      w_illegal = 1'b0;
    end
    if (w_illegal) begin
      w_fault = 2'b10;
    end else if (w_misal) begin
      w_fault = 2'b01;
    end else begin
      w_fault = 2'b00;
    end
  end

  // Next-state logic with completion cause
  always_comb begin
    w_nx        = r_state;
    w_cause_nx  = 2'b00;
    w_load_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (valid_i && w_en) begin
          if (w_fault != 2'b00) begin
            w_nx       = S_DONE;
            w_cause_nx = w_fault;
          end else begin
            w_nx = S_REQ;
          end
        end else begin
          w_nx = S_IDLE;
        end
      end
      S_REQ: begin
        if (dm_gnt_i) begin
          if (r_we) begin
            w_nx = S_DONE;
          end else if (dm_rvalid_i) begin
            w_nx        = S_DONE;
            w_load_done = 1'b1;
          end else begin
            w_nx = S_WAIT;
          end
        end else if (w_tmo) begin
          w_nx       = S_DONE;
          w_cause_nx = 2'b11;
        end else begin
          w_nx = S_REQ;
        end
      end
      S_WAIT: begin
        if (dm_rvalid_i) begin
          w_nx        = S_DONE;
          w_load_done = 1'b1;
        end else if (w_tmo) begin
          w_nx       = S_DONE;
          w_cause_nx = 2'b11;
        end else begin
          w_nx = S_WAIT;
        end
      end
      S_DONE:  w_nx = S_IDLE;
      default: w_nx = S_IDLE;
    endcase
  end

  // Load lane extraction: shift the addressed bytes down, then sign/zero extend
  always_comb begin
    w_sh   = dm_rdata_i >> {r_off, 3'b000};
    w_keep = '1;
    w_sbit = 1'b0;
    case (r_f3[1:0])
      2'b00: begin w_keep = XLEN'(8'hFF);          w_sbit = w_sh[7];      end
      2'b01: begin w_keep = XLEN'(16'hFFFF);       w_sbit = w_sh[15];     end
      2'b10: begin w_keep = XLEN'(32'hFFFF_FFFF);  w_sbit = w_sh[31];     end
      default: begin w_keep = '1;                  w_sbit = w_sh[XLEN-1]; end
    endcase
    w_ext = (w_sh & w_keep) | ({XLEN{w_sbit & ~r_f3[2]}} & ~w_keep);
  end

  // State register and bus timeout counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nx;
      if (w_accept) begin
        r_cnt <= '0;
      end else if ((r_state == S_REQ) || (r_state == S_WAIT)) begin
        r_cnt <= r_cnt + CW'(1);
      end else begin
        r_cnt <= r_cnt;
      end
    end
  end

  // Transaction capture and registered bus/completion outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_f3 <= 3'b000; r_we <= 1'b0; r_off <= '0; r_rd_lat <= 5'd0;
      r_req <= 1'b0; r_done <= 1'b0; r_exc <= 1'b0; r_cause <= 2'b00; r_dm_we <= 1'b0;
      r_dm_addr <= '0; r_dm_be <= '0; r_dm_wdata <= '0; r_rdata <= '0; r_rd <= 5'd0;
    end else begin
      r_req   <= (w_nx == S_REQ);
      r_done  <= (w_nx == S_DONE);
      r_exc   <= (w_nx == S_DONE) && (w_cause_nx != 2'b00);
      r_cause <= (w_nx == S_DONE) ? w_cause_nx : 2'b00;
      if (w_accept) begin
        r_f3 <= w_f3; r_we <= w_we; r_off <= w_off; r_rd_lat <= rd_i;
      end else begin
        r_f3 <= r_f3; r_we <= r_we; r_off <= r_off; r_rd_lat <= r_rd_lat;
      end
      if (w_accept && (w_fault == 2'b00)) begin
        r_dm_we    <= w_we;
        r_dm_addr  <= {addr_i[AW-1:OW], {OW{1'b0}}};
        r_dm_be    <= w_bmask << w_off;
        r_dm_wdata <= wdata_i << {w_off, 3'b000};
      end else if (w_nx != S_REQ) begin
        r_dm_we <= 1'b0; r_dm_addr <= '0; r_dm_be <= '0; r_dm_wdata <= '0;
      end else begin
        r_dm_we <= r_dm_we; r_dm_addr <= r_dm_addr; r_dm_be <= r_dm_be; r_dm_wdata <= r_dm_wdata;
      end
      if (w_load_done) begin
        r_rdata <= w_ext;
        r_rd    <= r_rd_lat;
      end else begin
        r_rdata <= r_rdata;
        r_rd    <= r_rd;
      end
    end
  end

  assign stall_o     = ((r_state == S_IDLE) && valid_i && w_en) ||
                       (r_state == S_REQ) || (r_state == S_WAIT);
  assign done_o      = r_done;
  assign exc_o       = r_exc;
  assign exc_cause_o = r_cause;
  assign rdata_o     = r_rdata;
  assign rd_o        = r_rd;
  assign dm_req_o    = r_req;
  assign dm_we_o     = r_dm_we;
  assign dm_addr_o   = r_dm_addr;
  assign dm_be_o     = r_dm_be;
  assign dm_wdata_o  = r_dm_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a 32-bit and a 64-bit instance share
// one clock/reset; expected completions are queued at issue and popped on done_o.
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_valid = 0, a_gnt = 0, a_rvalid = 0;
  logic [4:0]  a_op = 0, a_rd = 0, a_rdo;
  logic [31:0] a_addr = 0, a_wdata = 0, a_mrdata = 0, a_rdata, a_daddr, a_dwdata;
  logic        a_stall, a_done, a_exc, a_req, a_we;
  logic [1:0]  a_cause;
  logic [3:0]  a_be;

  logic        b_valid = 0, b_gnt = 0, b_rvalid = 0;
  logic [4:0]  b_op = 0, b_rd = 0, b_rdo;
  logic [31:0] b_addr = 0, b_daddr;
  logic [63:0] b_wdata = 0, b_mrdata = 0, b_rdata, b_dwdata;
  logic        b_stall, b_done, b_exc, b_req, b_we;
  logic [1:0]  b_cause;
  logic [7:0]  b_be;

  mem_access_unit #(.XLEN(32), .AW(32), .TIMEOUT(15)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .valid_i(a_valid), .memOp_i(a_op), .addr_i(a_addr),
    .wdata_i(a_wdata), .rd_i(a_rd), .stall_o(a_stall), .done_o(a_done),
    .rdata_o(a_rdata), .rd_o(a_rdo), .exc_o(a_exc), .exc_cause_o(a_cause),
    .dm_req_o(a_req), .dm_we_o(a_we), .dm_addr_o(a_daddr), .dm_be_o(a_be),
    .dm_wdata_o(a_dwdata), .dm_gnt_i(a_gnt), .dm_rvalid_i(a_rvalid), .dm_rdata_i(a_mrdata));

  mem_access_unit #(.XLEN(64), .AW(32), .TIMEOUT(15)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .valid_i(b_valid), .memOp_i(b_op), .addr_i(b_addr),
    .wdata_i(b_wdata), .rd_i(b_rd), .stall_o(b_stall), .done_o(b_done),
    .rdata_o(b_rdata), .rd_o(b_rdo), .exc_o(b_exc), .exc_cause_o(b_cause),
    .dm_req_o(b_req), .dm_we_o(b_we), .dm_addr_o(b_daddr), .dm_be_o(b_be),
    .dm_wdata_o(b_dwdata), .dm_gnt_i(b_gnt), .dm_rvalid_i(b_rvalid), .dm_rdata_i(b_mrdata));

  typedef struct {
    logic [63:0] rdata;
    logic [4:0]  rd;
    logic        exc;
    logic [1:0]  cause;
    int          done_cyc;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] last_rdata[2];
  logic [4:0]  last_rd[2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One transaction: gnt_at/rv_at are the cycle numbers (cycle 0 = accept) of the
  // memory handshake, -1 for never.
  task automatic run(input bit w64, input [2:0] f3, input bit we, input [31:0] addr,
                     input [63:0] wdata, input [4:0] rd, input int gnt_at, input int rv_at,
                     input [63:0] mrdata, input [63:0] exp_val, input [1:0] exp_cause,
                     input int exp_done, input [31:0] exp_daddr, input [7:0] exp_be,
                     input [63:0] exp_dwdata);
    exp_t e, got_e;
    int idx, exp_req, reqc, stallc, excbad;
    bit seen;
    logic s_req, s_done, s_stall, s_exc, s_we;
    logic [1:0] s_cause;
    logic [63:0] s_rdata, s_dwdata;
    logic [31:0] s_daddr;
    logic [7:0] s_be;
    logic [4:0] s_rdo;
    idx = w64 ? 1 : 0;
    if (exp_cause == 2'b11) exp_req = 15;
    else if (exp_cause != 2'b00) exp_req = 0;
    else exp_req = gnt_at;
    if (exp_cause == 2'b00 && !we) begin
      last_rdata[idx] = exp_val;
      last_rd[idx]    = rd;
    end
    e.rdata = last_rdata[idx]; e.rd = last_rd[idx];
    e.exc = (exp_cause != 2'b00); e.cause = exp_cause; e.done_cyc = exp_done;
    sb.push_back(e);
    seen = 0; reqc = 0; stallc = 0; excbad = 0;
    @(posedge clk); #1;
    for (int cyc = 0; cyc < 40 && !seen; cyc++) begin
      if (w64) begin
        b_valid = (cyc == 0); b_op = {f3, we, 1'b1}; b_addr = addr; b_wdata = wdata;
        b_rd = rd; b_gnt = (cyc == gnt_at); b_rvalid = (cyc == rv_at); b_mrdata = mrdata;
      end else begin
        a_valid = (cyc == 0); a_op = {f3, we, 1'b1}; a_addr = addr; a_wdata = wdata[31:0];
        a_rd = rd; a_gnt = (cyc == gnt_at); a_rvalid = (cyc == rv_at); a_mrdata = mrdata[31:0];
      end
      @(negedge clk);
      if (w64) begin
        s_req = b_req; s_done = b_done; s_stall = b_stall; s_exc = b_exc; s_we = b_we;
        s_cause = b_cause; s_rdata = b_rdata; s_dwdata = b_dwdata; s_daddr = b_daddr;
        s_be = b_be; s_rdo = b_rdo;
      end else begin
        s_req = a_req; s_done = a_done; s_stall = a_stall; s_exc = a_exc; s_we = a_we;
        s_cause = a_cause; s_rdata = {32'h0, a_rdata}; s_dwdata = {32'h0, a_dwdata};
        s_daddr = a_daddr; s_be = {4'h0, a_be}; s_rdo = a_rdo;
      end
      if (s_stall) stallc++;
      if (s_req) reqc++;
      if (cyc == 1 && exp_req > 0) begin
        check("dm_addr", {32'h0, s_daddr}, {32'h0, exp_daddr});
        check("dm_be", {56'h0, s_be}, {56'h0, exp_be});
        check("dm_wdata", s_dwdata, exp_dwdata);
        check("dm_we", {63'h0, s_we}, {63'h0, we});
      end
      if (s_done) begin
        seen = 1;
        got_e = sb.pop_front();
        check("done_cycle", 64'(cyc), 64'(got_e.done_cyc));
        check("exc", {63'h0, s_exc}, {63'h0, got_e.exc});
        check("cause", {62'h0, s_cause}, {62'h0, got_e.cause});
        check("rdata", s_rdata, got_e.rdata);
        check("rd", {59'h0, s_rdo}, {59'h0, got_e.rd});
        check("stall_in_done", {63'h0, s_stall}, 64'h0);
      end else begin
        if (s_exc) excbad++;
        @(posedge clk); #1;
      end
    end
    a_valid = 0; a_gnt = 0; a_rvalid = 0;
    b_valid = 0; b_gnt = 0; b_rvalid = 0;
    if (!seen && sb.size() > 0) got_e = sb.pop_front();
    check("done_seen", {63'h0, seen}, 64'h1);
    check("req_cycles", 64'(reqc), 64'(exp_req));
    check("stall_cycles", 64'(stallc), 64'(exp_done));
    check("exc_outside_done", 64'(excbad), 64'h0);
  endtask

  initial begin
    last_rdata[0] = '0; last_rdata[1] = '0; last_rd[0] = '0; last_rd[1] = '0;
    #12;
    check("rst_req", {63'h0, a_req}, 64'h0);
    check("rst_done", {63'h0, a_done}, 64'h0);
    check("rst_rdata", {32'h0, a_rdata}, 64'h0);
    check("rst_be64", {56'h0, b_be}, 64'h0);
    @(posedge clk); #1 rst_n = 1'b1;

    // XLEN=32 loads, stores, faults and timeout
    run(0, 3'b000, 0, 32'h1003, 64'h0, 5'd5, 1, 1, 64'h80AABBCC, 64'hFFFFFF80, 2'b00, 2, 32'h1000, 8'h08, 64'h0);
    run(0, 3'b100, 0, 32'h1003, 64'h0, 5'd6, 1, 1, 64'h80AABBCC, 64'h00000080, 2'b00, 2, 32'h1000, 8'h08, 64'h0);
    run(0, 3'b001, 1, 32'h2002, 64'h1234ABCD, 5'd7, 1, -1, 64'h0, 64'h0, 2'b00, 2, 32'h2000, 8'h0C, 64'hABCD0000);
    run(0, 3'b001, 0, 32'h1002, 64'h0, 5'd8, 1, 1, 64'h80AABBCC, 64'hFFFF80AA, 2'b00, 2, 32'h1000, 8'h0C, 64'h0);
    run(0, 3'b101, 0, 32'h1002, 64'h0, 5'd9, 1, 1, 64'h80AABBCC, 64'h000080AA, 2'b00, 2, 32'h1000, 8'h0C, 64'h0);
    run(0, 3'b010, 0, 32'h1000, 64'h0, 5'd10, 2, 4, 64'h80AABBCC, 64'h80AABBCC, 2'b00, 5, 32'h1000, 8'h0F, 64'h0);
    run(0, 3'b000, 1, 32'h0043, 64'h5A, 5'd11, 3, -1, 64'h0, 64'h0, 2'b00, 4, 32'h0040, 8'h08, 64'h5A000000);
    run(0, 3'b010, 0, 32'h2001, 64'h0, 5'd12, -1, -1, 64'h0, 64'h0, 2'b01, 1, 32'h0, 8'h0, 64'h0);
    run(0, 3'b011, 0, 32'h0000, 64'h0, 5'd13, -1, -1, 64'h0, 64'h0, 2'b10, 1, 32'h0, 8'h0, 64'h0);
    run(0, 3'b111, 0, 32'h0001, 64'h0, 5'd14, -1, -1, 64'h0, 64'h0, 2'b10, 1, 32'h0, 8'h0, 64'h0);
    run(0, 3'b100, 1, 32'h0000, 64'h0, 5'd15, -1, -1, 64'h0, 64'h0, 2'b10, 1, 32'h0, 8'h0, 64'h0);
    run(0, 3'b110, 0, 32'h0000, 64'h0, 5'd16, -1, -1, 64'h0, 64'h0, 2'b10, 1, 32'h0, 8'h0, 64'h0);
    run(0, 3'b001, 1, 32'h2001, 64'h0, 5'd17, -1, -1, 64'h0, 64'h0, 2'b01, 1, 32'h0, 8'h0, 64'h0);
    run(0, 3'b010, 0, 32'h0100, 64'h0, 5'd18, -1, -1, 64'h0, 64'h0, 2'b11, 16, 32'h0100, 8'h0F, 64'h0);

    // workEn low: no action
    @(posedge clk); #1 a_valid = 1; a_op = {3'b010, 1'b0, 1'b0};
    @(negedge clk); check("noen_stall", {63'h0, a_stall}, 64'h0);
    @(posedge clk); #1 a_valid = 0;
    @(negedge clk); check("noen_req", {63'h0, a_req}, 64'h0);

    // Reset in WAIT, then a late rvalid must be ignored
    @(posedge clk); #1 a_valid = 1; a_op = {3'b010, 1'b0, 1'b1}; a_addr = 32'h300; a_rd = 5'd20;
    @(posedge clk); #1 a_valid = 0; a_gnt = 1;
    @(posedge clk); #1 a_gnt = 0;
    check("pre_rst_stall", {63'h0, a_stall}, 64'h1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_req", {63'h0, a_req}, 64'h0);
    check("rst_mid_stall", {63'h0, a_stall}, 64'h0);
    last_rdata[0] = '0; last_rdata[1] = '0; last_rd[0] = '0; last_rd[1] = '0;
    a_rvalid = 1; a_mrdata = 32'h12345678;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("late_rvalid_done", {63'h0, a_done}, 64'h0);
    @(negedge clk);
    check("late_rvalid_done2", {63'h0, a_done}, 64'h0);
    check("late_rvalid_rdata", {32'h0, a_rdata}, 64'h0);
    a_rvalid = 0;
    run(0, 3'b010, 1, 32'h0040, 64'hDEADBEEF, 5'd21, 1, -1, 64'h0, 64'h0, 2'b00, 2, 32'h0040, 8'h0F, 64'hDEADBEEF);

    // XLEN=64
    run(1, 3'b110, 0, 32'h0014, 64'h0, 5'd3, 1, 1, 64'hF0000001_00000000, 64'h00000000_F0000001, 2'b00, 2, 32'h0010, 8'hF0, 64'h0);
    run(1, 3'b010, 0, 32'h0014, 64'h0, 5'd4, 1, 1, 64'hF0000001_00000000, 64'hFFFFFFFF_F0000001, 2'b00, 2, 32'h0010, 8'hF0, 64'h0);
    run(1, 3'b011, 0, 32'h0008, 64'h0, 5'd5, 1, 1, 64'h01234567_89ABCDEF, 64'h01234567_89ABCDEF, 2'b00, 2, 32'h0008, 8'hFF, 64'h0);
    run(1, 3'b000, 0, 32'h0007, 64'h0, 5'd6, 1, 2, 64'h80000000_00000000, 64'hFFFFFFFF_FFFFFF80, 2'b00, 3, 32'h0000, 8'h80, 64'h0);
    run(1, 3'b010, 1, 32'h000C, 64'h11223344, 5'd7, 1, -1, 64'h0, 64'h0, 2'b00, 2, 32'h0008, 8'hF0, 64'h11223344_00000000);
    run(1, 3'b011, 0, 32'h000C, 64'h0, 5'd8, -1, -1, 64'h0, 64'h0, 2'b01, 1, 32'h0, 8'h0, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Parametrised memory-stage access unit that turns the 5-bit MEM-stage operation word into a complete data-memory transaction. It generates the request/grant/response handshake toward data memory, byte lanes, store data alignment, load extraction with sign/zero extension, misalignment/illegal-width detection and a bus timeout. It sits between the MEM-stage decoder and data memory and stalls the pipeline while a transaction is outstanding.

## Interface
- XLEN, 32: data width, 32 or 64.
- AW, 32: address width.
- TIMEOUT, 15: max cycles in REQ+WAIT before a bus fault; must be ≥1.
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- valid_i  in  1  MEM-stage instruction valid.
- memOp_i  in  5  {funct3[2:0], dmWR, workEn}.
- addr_i  in  AW  effective address.
- wdata_i  in  XLEN  store data, right-aligned.
- rd_i  in  5  load destination register.
- stall_o  out  1  hold upstream pipeline.
- done_o  out  1  one-cycle completion pulse.
- rdata_o  out  XLEN  extended load result; rd_o  out  5  its destination.
- exc_o  out  1  exception on this completion; exc_cause_o  out  2  01 misaligned, 10 illegal width, 11 bus timeout.
- dm_req_o  out  1; dm_we_o  out  1; dm_addr_o  out  AW (offset bits zero); dm_be_o  out  XLEN/8; dm_wdata_o  out  XLEN.
- dm_gnt_i  in  1  request accepted; dm_rvalid_i  in  1  load data valid; dm_rdata_i  in  XLEN.

## Operation
- States: IDLE, REQ, WAIT, DONE. Reset: IDLE; every output 0.
- IDLE: valid_i & workEn accepts; addr, funct3, dmWR, wdata, rd latched. valid_i & !workEn: no action.
- Width size from funct3[1:0] (B/H/W/D); funct3[2]=1 selects unsigned load (LBU/LHU/LWU).
- Illegal: funct3=011 or 110 at XLEN=32; any store with funct3[2]=1; funct3=111. Cause 10 wins over 01.
- Misaligned: addr not a multiple of size. Fault on accept -> DONE, no dm_req_o.
- Legal -> REQ: dm_req_o=1, signals stable until dm_gnt_i. Store + gnt -> DONE. Load + gnt: dm_rvalid_i same cycle -> DONE, else WAIT. WAIT: dm_rvalid_i -> DONE.
- off = addr[log2(XLEN/8)-1:0]. dm_be_o = size mask << off; dm_wdata_o = wdata << 8·off; dm_addr_o = addr with off cleared.
- Load: (dm_rdata_i >> 8·off) truncated to size, sign- or zero-extended to XLEN; latched into rdata_o on rvalid.
- Timeout counter clears on accept, increments each REQ/WAIT cycle; reaching TIMEOUT -> DONE, cause 11, dm_req_o dropped.
- DONE: done_o=1, exc_o/cause valid, rd_o valid; next state IDLE. rdata_o, rd_o hold until next load completion; exc_o high only in DONE.
- stall_o = (IDLE & valid_i & workEn) | REQ | WAIT; 0 in DONE.
- rst_n low mid-transaction: immediate IDLE, dm_req_o 0, no done_o; late dm_rvalid_i ignored in IDLE.

## Timing
- Accept at cycle 0; dm_req_o first high cycle 1 (registered).
- Store, immediate grant: done_o at cycle 2.
- Load, grant + rvalid in cycle 1: done_o cycle 2; rvalid in cycle k: done_o cycle k+1.
- Fault on accept: done_o cycle 1, exc_o=1.
- Timeout: with no grant, dm_req_o high cycles 1..TIMEOUT, done_o cycle TIMEOUT+1.
- New op may be accepted in the cycle after DONE (IDLE); no back-to-back acceptance in DONE.

## Test plan
- XLEN=32, LB (000) addr 0x1003, dm_rdata 0x80AABBCC, gnt+rvalid cycle 1 -> done_o cycle 2, rdata_o 0xFFFFFF80; LBU (100) same -> 0x00000080.
- SH (001) addr 0x2002, wdata 0x1234ABCD, gnt cycle 1 -> dm_addr 0x2000, dm_be 4'b1100, dm_wdata 0xABCD0000, dm_we 1, done_o cycle 2, exc_o 0.
- LW addr 0x2001 -> no dm_req_o, done_o cycle 1, exc_o 1, cause 01; funct3 011 at XLEN=32 -> cause 10.
- TIMEOUT=15, load never granted -> dm_req_o high cycles 1-15, done_o cycle 16, cause 11, stall_o falls cycle 16.
- rst_n low during WAIT -> dm_req_o 0 and stall_o 0 immediately, no done_o; following SW addr 0x40 completes normally at cycle 2.
- XLEN=64, LWU (110) addr 0x14, dm_rdata 0xF0000001_00000000 -> dm_be 8'hF0, rdata_o 0x00000000F0000001; LD addr 0x8 -> full 64-bit word.
